// File: rtl/bist_pkg.sv
// Shared types and helpers for the multi-lane BIST pattern generator.
//   mode_e    : pattern selector (INC, PRBS, WALK1, CHKBD)
//   state_e   : control FSM states
//   lfsr_next : one XNOR-LFSR shift-left step for widths 8/16/32/64
package bist_pkg;

  localparam int unsigned MODE_W   = 2;
  localparam int unsigned LFSR_MAX = 64;

  typedef enum logic [MODE_W-1:0] {
    MODE_INC   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_CHKBD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // XNOR feedback keeps the all-zero state legal, so a lane seeded with 0 still runs.
  // Result is 64 bits wide; the caller truncates to its own width.
  function automatic logic [LFSR_MAX-1:0] lfsr_next(input int unsigned width,
                                                     input logic [LFSR_MAX-1:0] value);
    logic fb;
    case (width)
      8:       fb = ~(value[7]  ^ value[5]  ^ value[4]  ^ value[3]);
      16:      fb = ~(value[15] ^ value[14] ^ value[12] ^ value[3]);
      32:      fb = ~(value[31] ^ value[21] ^ value[1]  ^ value[0]);
      64:      fb = ~(value[63] ^ value[62] ^ value[60] ^ value[59]);
      default: fb = 1'b0;
    endcase
    return {value[LFSR_MAX-2:0], fb};
  endfunction

endpackage

// File: rtl/bist_lane.sv
// One lane of the BIST pattern generator: holds the next pattern value to present,
// loads the per-mode seed and advances one step per generated beat.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   seed       load the seed value for the selected mode
//   advance    step the pattern once (a beat was just taken from this lane)
//   mode       pattern selector (bist_pkg::mode_e encoding)
//   value      current lane pattern value
module bist_lane
  import bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_IDX   = 0,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed,
  input  logic                  advance,
  input  logic [MODE_W-1:0]     mode,
  output logic [DATA_WIDTH-1:0] value
);

  localparam int unsigned           WALK_POS = LANE_IDX % DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] INC_STEP = DATA_WIDTH'(NUM_CH);
  localparam logic [DATA_WIDTH-1:0] CHK_ODD  = {(DATA_WIDTH/2){2'b01}};
  localparam logic [DATA_WIDTH-1:0] CHK_EVEN = {(DATA_WIDTH/2){2'b10}};

  logic [DATA_WIDTH-1:0] seed_val;
  logic [DATA_WIDTH-1:0] next_val;

  // Seed and successor value for the selected mode.
  always_comb begin
    seed_val = '0;
    next_val = value;
    case (mode_e'(mode))
      MODE_INC: begin
        seed_val = DATA_WIDTH'(LANE_IDX);
        next_val = value + INC_STEP;
      end
      MODE_PRBS: begin
        seed_val = DATA_WIDTH'(LANE_IDX);
        next_val = DATA_WIDTH'(lfsr_next(DATA_WIDTH, LFSR_MAX'(value)));
      end
      MODE_WALK1: begin
        seed_val = DATA_WIDTH'(1) << WALK_POS;
        next_val = {value[DATA_WIDTH-2:0], value[DATA_WIDTH-1]};
      end
      MODE_CHKBD: begin
        seed_val = ((LANE_IDX % 2) == 1) ? CHK_ODD : CHK_EVEN;
        next_val = ~value;
      end
      default: ;
    endcase
  end

  // Lane register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (seed) begin
      value <= seed_val;
    end else if (advance) begin
      value <= next_val;
    end
  end

endmodule

// File: rtl/bist_pattern_gen.sv
// Multi-lane BIST pattern generator. NUM_CH lanes of INC / PRBS / WALK1 / CHKBD data
// with rate division, finite or infinite bursts and valid/ready backpressure.
// Optional feature macro: BIST_ERR_INJECT_EN adds input err_inject, which flips bit 0
// of lane 0 on the next generated beat (output only, pattern state untouched).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       level; low pauses generation without reseeding
//   start, stop  pulses; start arms/seeds a run from IDLE/DONE, stop aborts to IDLE
//   mode         pattern select, sampled in SEED
//   burst_len    beats per run (0 = infinite), sampled in SEED
//   data_out     lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_out    data_out holds a beat; accepted when valid_out & ready_in
//   ready_in     downstream ready
//   sync         high with the first beat of each run
//   done         one-cycle pulse after the final beat of a finite burst is accepted
//   busy         FSM not in IDLE
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RATE_DIV   = 1,
  parameter int unsigned BURST_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  input  logic [BURST_W-1:0]           burst_len,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         sync,
  output logic                         done,
  output logic                         busy
`ifdef BIST_ERR_INJECT_EN
  ,
  input  logic                         err_inject
`endif
);

  localparam int unsigned       BUS_W     = NUM_CH * DATA_WIDTH;
  localparam int unsigned       RATE_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_DIV - 1);

  // Elaboration-time parameter legality.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("bist_pattern_gen: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("bist_pattern_gen: NUM_CH must be 1..16");
  end
  if (RATE_DIV < 1 || RATE_DIV > 128) begin : g_bad_div
    $error("bist_pattern_gen: RATE_DIV must be 1..128");
  end

  state_e               state;
  state_e               next_state;
  logic [MODE_W-1:0]    mode_q;
  logic [BURST_W-1:0]   blen_q;
  logic [BURST_W-1:0]   beat_cnt;
  logic [RATE_W-1:0]    rate_cnt;
  logic                 first_q;
  logic [BUS_W-1:0]     lane_data;
  logic [BUS_W-1:0]     flip_c;
  logic [MODE_W-1:0]    lane_mode_c;
  logic [BURST_W:0]     accepted_c;
  logic                 hs_c;
  logic                 slot_free_c;
  logic                 rate_hit_c;
  logic                 budget_ok_c;
  logic                 gen_c;
  logic                 final_hs_c;
  logic                 seed_c;

  // Handshake and beat-generation qualifiers.
  assign hs_c        = valid_out & ready_in;
  assign slot_free_c = ~valid_out | hs_c;
  assign rate_hit_c  = (rate_cnt == RATE_LAST);
  // Beats accepted once this cycle's handshake lands; at most one beat is ever in flight,
  // so a new one may be generated only while this stays below the burst length.
  assign accepted_c  = {1'b0, beat_cnt} + {{BURST_W{1'b0}}, hs_c};
  assign budget_ok_c = (blen_q == '0) || (accepted_c < {1'b0, blen_q});
  assign gen_c       = (state == ST_RUN) & enable & rate_hit_c & slot_free_c & budget_ok_c & ~stop;
  assign final_hs_c  = hs_c & (blen_q != '0) & (beat_cnt == blen_q - BURST_W'(1));
  assign seed_c      = (state == ST_SEED);
  // Lanes see the live mode while seeding, the captured mode afterwards.
  assign lane_mode_c = seed_c ? mode : mode_q;

`ifdef BIST_ERR_INJECT_EN
  logic inj_pend;
  logic inj_c;

  // A pulse arms one injection; it is consumed by the next generated beat.
  assign inj_c  = inj_pend | err_inject;
  assign flip_c = {{(BUS_W-1){1'b0}}, inj_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_pend <= 1'b0;
    end else if (gen_c) begin
      inj_pend <= 1'b0;
    end else if (err_inject) begin
      inj_pend <= 1'b1;
    end
  end
`else
  assign flip_c = '0;
`endif

  // Lane array.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    bist_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_IDX   (g),
      .NUM_CH     (NUM_CH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .seed    (seed_c),
      .advance (gen_c),
      .mode    (lane_mode_c),
      .value   (lane_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; stop overrides everything, including a simultaneous start.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start && enable) next_state = ST_SEED;
      ST_SEED:  next_state = ST_RUN;
      ST_RUN: begin
        if (final_hs_c)   next_state = ST_DONE;
        else if (!enable) next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (final_hs_c)   next_state = ST_DONE;
        else if (enable)  next_state = ST_RUN;
      end
      ST_DONE:  next_state = (start && enable) ? ST_SEED : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (stop) begin
      next_state = ST_IDLE;
    end
  end

  // Run configuration, beat counter and first-beat flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= '0;
      blen_q   <= '0;
      beat_cnt <= '0;
      first_q  <= 1'b0;
    end else if (seed_c) begin
      mode_q   <= mode;
      blen_q   <= burst_len;
      beat_cnt <= '0;
      first_q  <= 1'b1;
    end else begin
      if (hs_c) beat_cnt <= beat_cnt + BURST_W'(1);
      if (gen_c) first_q <= 1'b0;
    end
  end

  // Rate divider: counts RUN cycles, holds in PAUSE, saturates while the slot is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_cnt <= '0;
    end else if (stop || (state != ST_RUN && state != ST_PAUSE)) begin
      rate_cnt <= '0;
    end else if (state == ST_RUN && enable) begin
      if (!rate_hit_c) begin
        rate_cnt <= rate_cnt + RATE_W'(1);
      end else if (gen_c) begin
        rate_cnt <= '0;
      end
    end
  end

  // Output handshake register; data/valid/sync hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sync      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= (next_state == ST_DONE);
      busy <= (next_state != ST_IDLE);
      if (stop) begin
        valid_out <= 1'b0;
        sync      <= 1'b0;
      end else if (gen_c) begin
        valid_out <= 1'b1;
        sync      <= first_q;
        data_out  <= lane_data ^ flip_c;
      end else if (hs_c) begin
        valid_out <= 1'b0;
        sync      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Bench for bist_pattern_gen: two instances (8-bit x2 lanes, DIV 1 and 16-bit x3 lanes,
// DIV 4) share one stimulus stream; every accepted beat is compared with a pattern model
// computed directly from beat index and lane number.
module tb_bist_pattern_gen;

  localparam int unsigned WA = 8,  CHA = 2, DIVA = 1;
  localparam int unsigned WB = 16, CHB = 3, DIVB = 4;
  localparam int unsigned BW = 16;

  logic clk;
  logic rst, enable, start, stop, ready;
  logic [1:0]    mode;
  logic [BW-1:0] burst_len;
`ifdef BIST_ERR_INJECT_EN
  logic err_inject;
`endif

  logic [CHA*WA-1:0] data_a;
  logic              valid_a, sync_a, done_a, busy_a;
  logic [CHB*WB-1:0] data_b;
  logic              valid_b, sync_b, done_b, busy_b;

  int n_asrt = 0;
  int n_fail = 0;

  int           k[2];
  int           inj_idx[2];
  logic         done_exp[2];
  logic         stall[2];
  logic [255:0] prev_data[2];
  logic         prev_sync[2];
  int           cur_mode;
  int           cur_blen;
  logic         rand_rdy;

  bist_pattern_gen #(.DATA_WIDTH(WA), .NUM_CH(CHA), .RATE_DIV(DIVA), .BURST_W(BW)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .data_out(data_a), .valid_out(valid_a), .ready_in(ready),
    .sync(sync_a), .done(done_a), .busy(busy_a)
`ifdef BIST_ERR_INJECT_EN
    , .err_inject(err_inject)
`endif
  );

  bist_pattern_gen #(.DATA_WIDTH(WB), .NUM_CH(CHB), .RATE_DIV(DIVB), .BURST_W(BW)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .data_out(data_b), .valid_out(valid_b), .ready_in(ready),
    .sync(sync_b), .done(done_b), .busy(busy_b)
`ifdef BIST_ERR_INJECT_EN
    , .err_inject(err_inject)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] prbs_step(input int w, input logic [63:0] v);
    int   t[4];
    logic fb;
    case (w)
      8:       t = '{7, 5, 4, 3};
      16:      t = '{15, 14, 12, 3};
      32:      t = '{31, 21, 1, 0};
      default: t = '{63, 62, 60, 59};
    endcase
    fb = ~(v[t[0]] ^ v[t[1]] ^ v[t[2]] ^ v[t[3]]);
    return ((v << 1) | {63'd0, fb}) & wmask(w);
  endfunction

  // Expected value of lane i on beat b (0-based) of a run.
  function automatic logic [63:0] exp_lane(input int w, input int ch, input int m,
                                           input int i, input int b);
    logic [63:0] v;
    case (m)
      0: v = 64'(i + b * ch);
      1: begin
        v = 64'(i);
        for (int n = 0; n < b; n++) v = prbs_step(w, v);
      end
      2: v = 64'd1 << ((i + b) % w);
      default: v = (((i + b) % 2) == 1) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
    endcase
    return v & wmask(w);
  endfunction

  // Called at the negative edge: checks done timing, stall stability and accepted beats.
  task automatic mon(input int id, input int w, input int ch, input logic v, input logic s,
                     input logic d, input logic [255:0] data);
    logic [63:0] got;
    logic [63:0] want;
    chk_b($sformatf("dut%0d_done_after_beat%0d", id, k[id]), d, done_exp[id]);
    done_exp[id] = 1'b0;
    if (stall[id]) begin
      chk_b($sformatf("dut%0d_hold_valid", id), v, 1'b1);
      chk_b($sformatf("dut%0d_hold_data", id), data == prev_data[id], 1'b1);
      chk_b($sformatf("dut%0d_hold_sync", id), s, prev_sync[id]);
    end
    if (v && cur_blen != 0)
      chk_b($sformatf("dut%0d_no_overrun", id), k[id] < cur_blen, 1'b1);
    if (v && ready) begin
      for (int i = 0; i < ch; i++) begin
        got  = 64'((data >> (i * w)) & 256'(wmask(w)));
        want = exp_lane(w, ch, cur_mode, i, k[id]);
        if (i == 0 && k[id] == inj_idx[id]) want = want ^ 64'd1;
        chk_v($sformatf("dut%0d_mode%0d_lane%0d_beat%0d", id, cur_mode, i, k[id]), got, want);
      end
      chk_b($sformatf("dut%0d_sync_beat%0d", id, k[id]), s, k[id] == 0);
      k[id]++;
      if (cur_blen != 0 && k[id] == cur_blen) done_exp[id] = 1'b1;
    end
    stall[id]     = v && !ready && !stop && !rst;
    prev_data[id] = data;
    prev_sync[id] = s;
  endtask

  task automatic step();
    if (rand_rdy) ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    mon(0, WA, CHA, valid_a, sync_a, done_a, 256'(data_a));
    mon(1, WB, CHB, valid_b, sync_b, done_b, 256'(data_b));
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int id = 0; id < 2; id++) begin
      k[id]        = 0;
      inj_idx[id]  = -1;
      done_exp[id] = 1'b0;
      stall[id]    = 1'b0;
    end
  endtask

  task automatic start_run(input int m, input int len);
    mode      = 2'(m);
    burst_len = BW'(len);
    cur_mode  = m;
    cur_blen  = len;
    clear_model();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_a || busy_b) && n < budget) begin
      step();
      n++;
    end
    chk_b("wait_idle_in_budget", busy_a || busy_b, 1'b0);
  endtask

  task automatic wait_ka(input int target, input int budget);
    int n = 0;
    while (k[0] < target && n < budget) begin
      step();
      n++;
    end
    chk_b("wait_beats_in_budget", k[0] >= target, 1'b1);
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_b("stop_valid_a", valid_a, 1'b0);
    chk_b("stop_busy_a", busy_a, 1'b0);
    chk_b("stop_valid_b", valid_b, 1'b0);
    chk_b("stop_busy_b", busy_b, 1'b0);
  endtask

  initial begin
    int kp_a;
    int kp_b;
    int n;
    int len;
    rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1;
    mode = '0; burst_len = '0; rand_rdy = 1'b0; cur_mode = 0; cur_blen = 0;
`ifdef BIST_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset_valid_a", valid_a, 1'b0);
    chk_b("reset_sync_a", sync_a, 1'b0);
    chk_b("reset_done_a", done_a, 1'b0);
    chk_b("reset_busy_a", busy_a, 1'b0);
    chk_v("reset_data_a", 64'(data_a), 64'd0);
    chk_b("reset_valid_b", valid_b, 1'b0);
    chk_v("reset_data_b", 64'(data_b), 64'd0);
    rst = 1'b0;
    step();

    // INC, 4 beats, full throughput: latency and first-beat contents.
    start_run(0, 4);
    chk_b("seed_busy_a", busy_a, 1'b1);
    chk_b("seed_valid_a", valid_a, 1'b0);
    step();
    chk_b("run0_valid_a", valid_a, 1'b0);
    step();
    chk_b("first_valid_a", valid_a, 1'b1);
    chk_b("first_sync_a", sync_a, 1'b1);
    chk_v("first_data_a", 64'(data_a), 64'h0100);
    wait_idle(100);
    chk_v("inc4_beats_a", 64'(k[0]), 64'd4);
    chk_v("inc4_beats_b", 64'(k[1]), 64'd4);

    // PRBS, infinite, continuous valid on the DIV=1 instance.
    start_run(1, 0);
    wait_ka(1, 20);
    for (int i = 0; i < 12; i++) begin
      chk_b("prbs_continuous_valid_a", valid_a, 1'b1);
      step();
    end
    stop_run();

    // INC with a three-cycle stall at beat 2.
    start_run(0, 6);
    wait_ka(2, 50);
    ready = 1'b0;
    repeat (3) step();
    ready = 1'b1;
    wait_idle(200);
    chk_v("stall_beats_a", 64'(k[0]), 64'd6);
    chk_v("stall_beats_b", 64'(k[1]), 64'd6);

    // WALK1, 10 beats, enable low for 5 cycles mid-run.
    start_run(2, 10);
    wait_ka(4, 50);
    enable = 1'b0;
    step();
    kp_a = k[0];
    kp_b = k[1];
    repeat (4) step();
    chk_v("pause_no_beats_a", 64'(k[0]), 64'(kp_a));
    chk_v("pause_no_beats_b", 64'(k[1]), 64'(kp_b));
    chk_b("pause_valid_a", valid_a, 1'b0);
    chk_b("pause_busy_a", busy_a, 1'b1);
    enable = 1'b1;
    wait_idle(300);
    chk_v("walk_beats_a", 64'(k[0]), 64'd10);
    chk_v("walk_beats_b", 64'(k[1]), 64'd10);

    // Infinite INC: start mid-run ignored, stop aborts, next start reseeds.
    start_run(0, 0);
    wait_ka(3, 50);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_ka(6, 50);
    stop_run();
    start_run(0, 2);
    wait_idle(100);
    chk_v("reseed_beats_a", 64'(k[0]), 64'd2);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk_b("start_stop_busy_a", busy_a, 1'b0);
    chk_b("start_stop_busy_b", busy_b, 1'b0);

    // CHKBD and random runs under random backpressure.
    rand_rdy = 1'b1;
    start_run(3, 6);
    wait_idle(300);
    chk_v("chkbd_beats_a", 64'(k[0]), 64'd6);
    for (int r = 0; r < 5; r++) begin
      len = int'($urandom_range(1, 9));
      start_run(int'($urandom_range(0, 3)), len);
      wait_idle(400);
      chk_v("rand_beats_a", 64'(k[0]), 64'(len));
      chk_v("rand_beats_b", 64'(k[1]), 64'(len));
    end
    rand_rdy = 1'b0;
    ready    = 1'b1;

    // Asynchronous reset mid-run.
    start_run(1, 0);
    wait_ka(3, 50);
    rst = 1'b1;
    #2;
    chk_b("midrst_valid_a", valid_a, 1'b0);
    chk_b("midrst_busy_a", busy_a, 1'b0);
    chk_v("midrst_data_a", 64'(data_a), 64'd0);
    chk_b("midrst_valid_b", valid_b, 1'b0);
    chk_v("midrst_data_b", 64'(data_b), 64'd0);
    clear_model();
    step();
    rst = 1'b0;
    step();
    chk_b("post_rst_busy_a", busy_a, 1'b0);

`ifdef BIST_ERR_INJECT_EN
    // Error injection on beat 2 while beat 1 is held by backpressure.
    ready = 1'b0;
    start_run(0, 4);
    n = 0;
    while (!(valid_a && valid_b) && n < 50) begin
      step();
      n++;
    end
    chk_b("inject_setup_in_budget", valid_a && valid_b, 1'b1);
    inj_idx[0] = 1;
    inj_idx[1] = 1;
    err_inject = 1'b1;
    step();
    err_inject = 1'b0;
    ready = 1'b1;
    wait_idle(100);
    chk_v("inject_beats_a", 64'(k[0]), 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
